bsg_cache_to_dram_ctrl_tx_packer: RTL and testbench
===================================================

Name: bsg_cache_to_dram_ctrl_tx_packer

Overview:
Write-data path from N cache DMA engines to a DRAM controller write-data FIFO (app_wdf_* interface).
- A tag FIFO queues which cache owns each pending write block.
- The block streams that cache's DMA words, packs data_width_p-bit words into dram_data_width_p-bit beats, and asserts app_wdf_end_o at each DRAM-burst boundary.
- Successor to the single-cache, no-packing tx path: adds a parametrised cache count, width ratio, burst length and block size.

Parameters:
num_cache_p, 4, number of cache DMA ports; tag width lg_num_cache_lp = max(1, clog2(num_cache_p)).
data_width_p, 32, DMA word width.
dram_data_width_p, 128, app_wdf data width; ratio_lp = dram_data_width_p/data_width_p, integer >= 1.
block_size_in_words_p, 8, words per cache block; must be a multiple of ratio_lp.
dram_ctrl_burst_len_p, 2, app_wdf beats per DRAM burst; beats_lp = block_size_in_words_p/ratio_lp must be a multiple of it.
tag_fifo_els_p, 4, tag FIFO depth (power of 2).

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset; synchronous, active-low
v_i  in  1  write-request valid
tag_i  in  lg_num_cache_lp  cache id of the request
ready_o  out  1  tag FIFO can accept (valid->ready handshake; enqueue = v_i & ready_o)
dma_data_i  in  num_cache_p*data_width_p  per-cache DMA words, cache c at [c*data_width_p +: data_width_p]
dma_data_v_i  in  num_cache_p  per-cache word valid
dma_data_yumi_o  out  num_cache_p  one-hot word consume
app_wdf_wren_o  out  1  beat valid
app_wdf_data_o  out  dram_data_width_p  packed beat
app_wdf_mask_o  out  dram_data_width_p/8  byte mask, constant all zeros (full writes)
app_wdf_end_o  out  1  last beat of a DRAM burst
app_wdf_rdy_i  in  1  controller accepts beat (transfer = wren & rdy)

Behaviour:
Reset (reset_n_i low at posedge):
- Tag FIFO emptied; word, beat and block-word counters cleared; beat buffer invalid.
- While reset_n_i is low, ready_o, dma_data_yumi_o, app_wdf_wren_o and app_wdf_end_o are 0.
- Reset mid-block discards the partial beat and all queued tags; nothing is flushed.

Tag FIFO:
- Enqueue on v_i & ready_o; ready_o = ~full.
- Head tag selects the active cache.
- Dequeue in the cycle the last beat of the block (beat_cnt == beats_lp-1) transfers.
- Simultaneous enqueue and dequeue when full: ready_o stays 0 that cycle, so the enqueue does not occur.

Word intake:
- dma_data_yumi_o[head] = tag valid & dma_data_v_i[head] & room & (blk_words < block_size_in_words_p).
- room = ~buf_full | (app_wdf_wren_o & app_wdf_rdy_i), i.e. drain and fill in the same cycle is allowed.
- All other yumi bits are 0; a yumi is never asserted without the matching v.
- Accepted word k of a beat lands in buf[k*data_width_p +: data_width_p] (word 0 = LSBs).
- word_cnt wraps ratio_lp-1 -> 0; buf_full sets when word ratio_lp-1 is written.

Beat output:
- app_wdf_wren_o = buf_full; app_wdf_data_o = buf.
- Data is stable while wren & ~rdy.
- Latency: ratio_lp cycles from first word accepted to wren.
- app_wdf_end_o = wren & ((beat_cnt mod dram_ctrl_burst_len_p) == dram_ctrl_burst_len_p-1).
- beat_cnt increments on each transfer and wraps at beats_lp.

Block boundary:
- blk_words counts accepted words per block and saturates at block_size_in_words_p, stalling intake.
- blk_words clears when the tag dequeues, so the next block's first word is accepted the cycle after the last beat transfers.
- Throughput: one word per cycle sustained within a block; one bubble per block.
- Tag FIFO empty: no yumi, no wren; word_cnt and beat_cnt retain their values.

Degenerate case ratio_lp = 1: the buffer still registers the word, with one cycle of latency.

Test Plan:
- Defaults: reset low 2 cycles -> ready_o=0, yumi=0, wren=0; release -> ready_o=1; tag FIFO empty, no yumi.
- tag=2, cache 2 streams words 0x0..0x7 with rdy=1 -> yumi_o=4'b0100 for 8 cycles; beats 0x3_2_1_0 then 0x7_6_5_4 (32-bit fields, word 0 in LSBs); end_o=0 on beat 0, 1 on beat 1; tag popped; mask=0.
- Backpressure: rdy=0 while beat valid -> one further word intake is blocked after buf_full; data held; rdy=1 -> transfer, and intake resumes the same cycle.
- Four tags 0,1,2,3 enqueued back-to-back -> ready_o=0 after the 4th; a 5th v_i is not enqueued; blocks drain in order 0,1,2,3 with only the head cache yumi'd.
- Cache 1 valid while head is tag 3 -> yumi[1] stays 0; no cross-cache consumption.
- Reset asserted after 5 of 8 words -> outputs 0; after release the FIFO is empty and a new block starts at word 0 / beat 0 with correct packing.

Source files
------------

// File: rtl/bsg_cache_to_dram_ctrl_tx_packer.sv
// Packs per-cache DMA write words into DRAM controller write beats (app_wdf_*).
// A tag FIFO orders the blocks; app_wdf_end_o marks each DRAM burst boundary.
module bsg_cache_to_dram_ctrl_tx_packer #(
  parameter int num_cache_p           = 4,
  parameter int data_width_p          = 32,
  parameter int dram_data_width_p     = 128,
  parameter int block_size_in_words_p = 8,
  parameter int dram_ctrl_burst_len_p = 2,
  parameter int tag_fifo_els_p        = 4,
  localparam int lg_num_cache_lp      = (num_cache_p > 1) ? $clog2(num_cache_p) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  v_i,
  input  logic [lg_num_cache_lp-1:0]            tag_i,
  output logic                                  ready_o,
  input  logic [num_cache_p*data_width_p-1:0]   dma_data_i,
  input  logic [num_cache_p-1:0]                dma_data_v_i,
  output logic [num_cache_p-1:0]                dma_data_yumi_o,
  output logic                                  app_wdf_wren_o,
  output logic [dram_data_width_p-1:0]          app_wdf_data_o,
  output logic [dram_data_width_p/8-1:0]        app_wdf_mask_o,
  output logic                                  app_wdf_end_o,
  input  logic                                  app_wdf_rdy_i
);

  localparam int ratio_lp      = dram_data_width_p / data_width_p;
  localparam int beats_lp      = block_size_in_words_p / ratio_lp;
  localparam int word_cnt_w_lp = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
  localparam int beat_cnt_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int blk_w_lp      = $clog2(block_size_in_words_p + 1);
  localparam int ptr_w_lp      = (tag_fifo_els_p > 1) ? $clog2(tag_fifo_els_p) : 1;
  localparam int cnt_w_lp      = $clog2(tag_fifo_els_p + 1);
  localparam int mask_w_lp     = dram_data_width_p / 8;

  // Circular pointer advance; explicit wrap keeps a depth of one correct.
  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    if (p == ptr_w_lp'(tag_fifo_els_p - 1)) begin
      return {ptr_w_lp{1'b0}};
    end else begin
      return p + ptr_w_lp'(1);
    end
  endfunction

  logic [lg_num_cache_lp-1:0]   tag_mem_q [tag_fifo_els_p];
  logic [ptr_w_lp-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [cnt_w_lp-1:0]          tag_cnt_q, tag_cnt_d;
  logic [word_cnt_w_lp-1:0]     word_cnt_q, word_cnt_d;
  logic [beat_cnt_w_lp-1:0]     beat_cnt_q, beat_cnt_d;
  logic [blk_w_lp-1:0]          blk_words_q, blk_words_d;
  logic [dram_data_width_p-1:0] buf_q, buf_d;
  logic                         buf_full_q, buf_full_d;

  logic                         tag_v_s, tag_full_s, enq_s, deq_s, xfer_s, room_s;
  logic                         yumi_s, head_v_s, last_word_s, last_beat_s;
  logic [lg_num_cache_lp-1:0]   head_tag_s;
  logic [data_width_p-1:0]      head_word_s;

  // Handshake decode and externally visible outputs, all held quiet in reset.
  always_comb begin
    tag_v_s         = (tag_cnt_q != cnt_w_lp'(0));
    tag_full_s      = (tag_cnt_q == cnt_w_lp'(tag_fifo_els_p));
    head_tag_s      = tag_mem_q[rd_ptr_q];
    ready_o         = reset_n_i & ~tag_full_s;
    enq_s           = v_i & ready_o;
    app_wdf_wren_o  = reset_n_i & buf_full_q;
    app_wdf_data_o  = buf_q;
    app_wdf_mask_o  = {mask_w_lp{1'b0}};
    xfer_s          = app_wdf_wren_o & app_wdf_rdy_i;
    last_beat_s     = (beat_cnt_q == beat_cnt_w_lp'(beats_lp - 1));
    last_word_s     = (word_cnt_q == word_cnt_w_lp'(ratio_lp - 1));
    deq_s           = xfer_s & last_beat_s;
    room_s          = ~buf_full_q | xfer_s;
    app_wdf_end_o   = app_wdf_wren_o
                    & ((int'(beat_cnt_q) % dram_ctrl_burst_len_p) == (dram_ctrl_burst_len_p - 1));
  end

  // Select the head cache's word and valid with an AND-OR mux.
  always_comb begin
    head_word_s = {data_width_p{1'b0}};
    head_v_s    = 1'b0;
    for (int c = 0; c < num_cache_p; c++) begin
      head_word_s = head_word_s
                  | ({data_width_p{head_tag_s == lg_num_cache_lp'(c)}}
                     & dma_data_i[c*data_width_p +: data_width_p]);
      head_v_s    = head_v_s | ((head_tag_s == lg_num_cache_lp'(c)) & dma_data_v_i[c]);
    end
  end

  // Word consume: only the head cache, only with buffer room and block budget left.
  always_comb begin
    yumi_s = tag_v_s & head_v_s & room_s
           & (blk_words_q < blk_w_lp'(block_size_in_words_p));
    for (int c = 0; c < num_cache_p; c++) begin
      dma_data_yumi_o[c] = reset_n_i & yumi_s & (head_tag_s == lg_num_cache_lp'(c));
    end
  end

  // Pack accepted words into the beat buffer, word 0 in the LSBs.
  always_comb begin
    buf_d = buf_q;
    for (int k = 0; k < ratio_lp; k++) begin
      if (yumi_s && (word_cnt_q == word_cnt_w_lp'(k))) begin
        buf_d[k*data_width_p +: data_width_p] = head_word_s;
      end else begin
        buf_d[k*data_width_p +: data_width_p] = buf_q[k*data_width_p +: data_width_p];
      end
    end
  end

  // Word, beat and block counters plus buffer-full flag.
  always_comb begin
    if (yumi_s) begin
      word_cnt_d = last_word_s ? word_cnt_w_lp'(0) : word_cnt_q + word_cnt_w_lp'(1);
    end else begin
      word_cnt_d = word_cnt_q;
    end

    // A fill completing a beat wins over a drain (ratio of one refills every cycle).
    if (yumi_s && last_word_s) begin
      buf_full_d = 1'b1;
    end else if (xfer_s) begin
      buf_full_d = 1'b0;
    end else begin
      buf_full_d = buf_full_q;
    end

    if (xfer_s) begin
      beat_cnt_d = last_beat_s ? beat_cnt_w_lp'(0) : beat_cnt_q + beat_cnt_w_lp'(1);
    end else begin
      beat_cnt_d = beat_cnt_q;
    end

    if (deq_s) begin
      blk_words_d = blk_w_lp'(0);
    end else if (yumi_s) begin
      blk_words_d = blk_words_q + blk_w_lp'(1);
    end else begin
      blk_words_d = blk_words_q;
    end
  end

  // Tag FIFO pointers and occupancy.
  always_comb begin
    wr_ptr_d = enq_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = deq_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({enq_s, deq_s})
      2'b10:   tag_cnt_d = tag_cnt_q + cnt_w_lp'(1);
      2'b01:   tag_cnt_d = tag_cnt_q - cnt_w_lp'(1);
      default: tag_cnt_d = tag_cnt_q;
    endcase
  end

  // Control and data state registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_ptr_q    <= {ptr_w_lp{1'b0}};
      wr_ptr_q    <= {ptr_w_lp{1'b0}};
      tag_cnt_q   <= {cnt_w_lp{1'b0}};
      word_cnt_q  <= {word_cnt_w_lp{1'b0}};
      beat_cnt_q  <= {beat_cnt_w_lp{1'b0}};
      blk_words_q <= {blk_w_lp{1'b0}};
      buf_q       <= {dram_data_width_p{1'b0}};
      buf_full_q  <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      tag_cnt_q   <= tag_cnt_d;
      word_cnt_q  <= word_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      blk_words_q <= blk_words_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
    end
  end

  // Tag storage; enqueue is already blocked while in reset.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      tag_mem_q[wr_ptr_q] <= tag_i;
    end else begin
      tag_mem_q[wr_ptr_q] <= tag_mem_q[wr_ptr_q];
    end
  end

endmodule

// File: tb/tb_bsg_cache_to_dram_ctrl_tx_packer.sv
// Directed bench for the DMA-to-app_wdf packer at default parameters
// (4 caches, 32->128 bit packing, 8-word blocks, burst length 2).
module tb_bsg_cache_to_dram_ctrl_tx_packer;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         v_i;
  logic [1:0]   tag_i;
  logic         ready_o;
  logic [127:0] dma_data_i;
  logic [3:0]   dma_data_v_i;
  logic [3:0]   dma_data_yumi_o;
  logic         app_wdf_wren_o;
  logic [127:0] app_wdf_data_o;
  logic [15:0]  app_wdf_mask_o;
  logic         app_wdf_end_o;
  logic         app_wdf_rdy_i;

  int checks = 0;
  int errors = 0;

  bsg_cache_to_dram_ctrl_tx_packer dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .v_i             (v_i),
    .tag_i           (tag_i),
    .ready_o         (ready_o),
    .dma_data_i      (dma_data_i),
    .dma_data_v_i    (dma_data_v_i),
    .dma_data_yumi_o (dma_data_yumi_o),
    .app_wdf_wren_o  (app_wdf_wren_o),
    .app_wdf_data_o  (app_wdf_data_o),
    .app_wdf_mask_o  (app_wdf_mask_o),
    .app_wdf_end_o   (app_wdf_end_o),
    .app_wdf_rdy_i   (app_wdf_rdy_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Active cache c presents word w; the others present a recognisable filler.
  task automatic drive_words(input int c, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      if (i == c) dma_data_i[i*32 +: 32] = w;
      else        dma_data_i[i*32 +: 32] = 32'hDEAD_0000 | 32'(i);
    end
  endtask

  task automatic enq(input logic [1:0] t, input logic exp_ready);
    v_i = 1'b1;
    tag_i = t;
    dma_data_v_i = 4'h0;
    #1;
    chk("enq_ready", 128'(ready_o), 128'(exp_ready));
    tick();
    v_i = 1'b0;
  endtask

  // Streams one full block from cache c with rdy held high: words base..base+7.
  task automatic run_block(input int c, input logic [31:0] base);
    for (int k = 0; k <= 8; k++) begin
      drive_words(c, base + 32'(k));
      dma_data_v_i = 4'hF;
      app_wdf_rdy_i = 1'b1;
      #1;
      chk("blk_yumi", 128'(dma_data_yumi_o), (k < 8) ? 128'(4'b0001 << c) : 128'h0);
      if (k == 4) begin
        chk("blk_wren0", 128'(app_wdf_wren_o), 128'h1);
        chk("blk_beat0", app_wdf_data_o, {base + 32'd3, base + 32'd2, base + 32'd1, base});
        chk("blk_end0", 128'(app_wdf_end_o), 128'h0);
      end else if (k == 8) begin
        chk("blk_wren1", 128'(app_wdf_wren_o), 128'h1);
        chk("blk_beat1", app_wdf_data_o, {base + 32'd7, base + 32'd6, base + 32'd5, base + 32'd4});
        chk("blk_end1", 128'(app_wdf_end_o), 128'h1);
        chk("blk_mask", 128'(app_wdf_mask_o), 128'h0);
      end else begin
        chk("blk_wren_idle", 128'(app_wdf_wren_o), 128'h0);
      end
      tick();
    end
  endtask

  initial begin
    reset_n_i = 1'b0;
    v_i = 1'b0;
    tag_i = 2'd0;
    dma_data_i = 128'h0;
    dma_data_v_i = 4'h0;
    app_wdf_rdy_i = 1'b1;

    // Reset held for two cycles.
    tick();
    tick();
    chk("rst_ready", 128'(ready_o), 128'h0);
    chk("rst_yumi", 128'(dma_data_yumi_o), 128'h0);
    chk("rst_wren", 128'(app_wdf_wren_o), 128'h0);
    chk("rst_end", 128'(app_wdf_end_o), 128'h0);

    // Release: FIFO empty, valid words are not consumed.
    reset_n_i = 1'b1;
    dma_data_v_i = 4'hF;
    #1;
    chk("rel_ready", 128'(ready_o), 128'h1);
    chk("rel_yumi", 128'(dma_data_yumi_o), 128'h0);
    chk("rel_wren", 128'(app_wdf_wren_o), 128'h0);
    tick();

    // Single block from cache 2.
    enq(2'd2, 1'b1);
    run_block(2, 32'h0);
    dma_data_v_i = 4'hF;
    #1;
    chk("pop_yumi", 128'(dma_data_yumi_o), 128'h0);
    chk("pop_wren", 128'(app_wdf_wren_o), 128'h0);
    chk("pop_ready", 128'(ready_o), 128'h1);

    // Backpressure on cache 1.
    enq(2'd1, 1'b1);
    app_wdf_rdy_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_words(1, 32'h10 + 32'(k));
      dma_data_v_i = 4'hF;
      #1;
      chk("bp_yumi_fill", 128'(dma_data_yumi_o), 128'h2);
      tick();
    end
    drive_words(1, 32'h14);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("bp_wren_hold", 128'(app_wdf_wren_o), 128'h1);
      chk("bp_yumi_block", 128'(dma_data_yumi_o), 128'h0);
      chk("bp_data_hold", app_wdf_data_o, {32'h13, 32'h12, 32'h11, 32'h10});
      chk("bp_end", 128'(app_wdf_end_o), 128'h0);
      tick();
    end
    app_wdf_rdy_i = 1'b1;
    #1;
    chk("bp_resume_yumi", 128'(dma_data_yumi_o), 128'h2);
    tick();
    for (int k = 5; k < 8; k++) begin
      drive_words(1, 32'h10 + 32'(k));
      #1;
      chk("bp_yumi_rest", 128'(dma_data_yumi_o), 128'h2);
      chk("bp_wren_rest", 128'(app_wdf_wren_o), 128'h0);
      tick();
    end
    #1;
    chk("bp_beat1", app_wdf_data_o, {32'h17, 32'h16, 32'h15, 32'h14});
    chk("bp_end1", 128'(app_wdf_end_o), 128'h1);
    tick();
    chk("bp_done_wren", 128'(app_wdf_wren_o), 128'h0);

    // Fill the tag FIFO; a fifth request is refused.
    enq(2'd0, 1'b1);
    enq(2'd1, 1'b1);
    enq(2'd2, 1'b1);
    enq(2'd3, 1'b1);
    chk("full_ready", 128'(ready_o), 128'h0);
    enq(2'd0, 1'b0);

    // Drain in order; cache 1 valid alone cannot steal from head tag 3.
    run_block(0, 32'h100);
    run_block(1, 32'h200);
    run_block(2, 32'h300);
    dma_data_v_i = 4'b0010;
    #1;
    chk("cross_yumi", 128'(dma_data_yumi_o), 128'h0);
    chk("cross_wren", 128'(app_wdf_wren_o), 128'h0);
    tick();
    run_block(3, 32'h400);
    dma_data_v_i = 4'hF;
    #1;
    chk("drained_yumi", 128'(dma_data_yumi_o), 128'h0);
    chk("drained_ready", 128'(ready_o), 128'h1);

    // Reset after five words of a block with a second tag queued.
    enq(2'd3, 1'b1);
    enq(2'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive_words(3, 32'h500 + 32'(k));
      dma_data_v_i = 4'hF;
      #1;
      chk("mid_yumi", 128'(dma_data_yumi_o), 128'h8);
      tick();
    end
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_ready", 128'(ready_o), 128'h0);
    chk("mid_rst_yumi", 128'(dma_data_yumi_o), 128'h0);
    chk("mid_rst_wren", 128'(app_wdf_wren_o), 128'h0);
    chk("mid_rst_end", 128'(app_wdf_end_o), 128'h0);
    tick();
    tick();
    reset_n_i = 1'b1;
    #1;
    chk("post_rst_ready", 128'(ready_o), 128'h1);
    chk("post_rst_yumi", 128'(dma_data_yumi_o), 128'h0);
    chk("post_rst_wren", 128'(app_wdf_wren_o), 128'h0);
    enq(2'd2, 1'b1);
    run_block(2, 32'h600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
